// File: rtl/swara_sequencer_if.sv
// Note stream from a melody source into the swara sequencer.
// Ports: note_valid/note_idx/note_len are driven by the source (master) and note_ready by the sequencer (slave).
// A note is accepted in any cycle where note_valid and note_ready are both high.
interface swara_sequencer_if;
  logic       note_valid;  // source has a (note, length) pair available
  logic       note_ready;  // sequencer takes the pair this cycle
  logic [4:0] note_idx;    // 0..20 swara, 30 end-of-song, 31 rest, 21..29 treated as rest
  logic [2:0] note_len;    // beats - 1

  modport master (
    output note_valid,
    output note_idx,
    output note_len,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_idx,
    input  note_len,
    output note_ready
  );
endinterface

// File: rtl/swara_sequencer.sv
// Purpose: plays a melody by fetching (note, length) pairs and holding each swara for whole beats.
// Latency: a note accepted at edge N sounds from N+1 for (note_len+1)*TICKS_PER_BEAT cycles.
// Backpressure: note_ready is high only in FETCH (and never while stop/rst is high); no data is consumed otherwise.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   start, stop         player control; start only acts when idle, stop aborts from any state
//   note (slave)        upstream note stream, see swara_sequencer_if
//   swara_idx, tone_en  drive of the tone generator (31 = silence)
//   note_strobe         one-cycle pulse on the first cycle of every accepted note, rests included
//   busy, song_done     state != IDLE; one-cycle pulse when the end-of-song marker is taken
//
// Build option: define SWARA_GAP_EN to add a silent articulation gap of GAP_TICKS cycles after every
// sounded note. Without it neither the GAP state nor its counter exists.
module swara_sequencer #(
  parameter int TICKS_PER_BEAT = 15_000_000,
  parameter int GAP_TICKS      = TICKS_PER_BEAT / 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  swara_sequencer_if.slave       note,
  output logic [4:0]             swara_idx,
  output logic                   tone_en,
  output logic                   note_strobe,
  output logic                   busy,
  output logic                   song_done
);

  localparam int            TW        = $clog2(TICKS_PER_BEAT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);

  localparam logic [4:0] IDX_SILENT   = 5'd31;
  localparam logic [4:0] IDX_END      = 5'd30;
  localparam logic [4:0] IDX_MAX_TONE = 5'd20;

  // Catch unusable timing parameters at elaboration instead of producing a silent or stuck player.
  if (TICKS_PER_BEAT < 2 || GAP_TICKS < 1) begin : g_param_check
    $error("swara_sequencer: TICKS_PER_BEAT must be >= 2 and GAP_TICKS >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PLAY  = 3'd2,
`ifdef SWARA_GAP_EN
    S_GAP   = 3'd4,
`endif
    S_DONE  = 3'd3
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [TW-1:0] tick_cnt;
  logic [2:0]    beat_cnt;
  logic          note_end;

  // The note being played: swara to drive and whether it is sounded at all (rests are not).
  logic [4:0]    note_swara;
  logic          note_tone;
  logic [4:0]    note_swara_nxt;
  logic          note_tone_nxt;

  logic          handshake;
  logic          hs_tone;
  logic          hs_end;

  logic [4:0]    swara_idx_nxt;
  logic          tone_en_nxt;
  logic          note_strobe_nxt;
  logic          busy_nxt;
  logic          song_done_nxt;

  // ---------------------------------------------------------------------------
  // Upstream handshake
  // ---------------------------------------------------------------------------
  // Ready is decoded straight from the state so the source sees it in the same cycle; stop and rst
  // mask it so that no note is swallowed on the cycle the player is being torn down.
  assign note.note_ready = (state == S_FETCH) && !stop && !rst;
  assign handshake       = note.note_valid && note.note_ready;
  assign hs_end          = (note.note_idx == IDX_END);
  assign hs_tone         = (note.note_idx <= IDX_MAX_TONE);

  // Last cycle of a note: final tick of the final beat.
  assign note_end = (state == S_PLAY) && (tick_cnt == TICK_LAST) && (beat_cnt == 3'd0);

`ifdef SWARA_GAP_EN
  localparam int            GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state == S_GAP && !stop && gap_cnt != GAP_LAST) begin
      gap_cnt <= gap_cnt + GW'(1);
    end else begin
      gap_cnt <= '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) next_state = S_FETCH;
        end
        S_FETCH: begin
          // No valid note simply keeps us waiting here, silent.
          if (handshake) next_state = hs_end ? S_DONE : S_PLAY;
        end
        S_PLAY: begin
          if (note_end) begin
`ifdef SWARA_GAP_EN
            next_state = note_tone ? S_GAP : S_FETCH;
`else
            next_state = S_FETCH;
`endif
          end
        end
`ifdef SWARA_GAP_EN
        S_GAP: begin
          if (gap_cnt == GAP_LAST) next_state = S_FETCH;
        end
`endif
        S_DONE: begin
          next_state = S_IDLE;
        end
        default: begin
          next_state = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  // Outputs are computed from the state being entered and registered, so every output toggles
  // together with the state register and is glitch-free at the tone generator.
  always_comb begin
    note_swara_nxt = note_swara;
    note_tone_nxt  = note_tone;
    if (handshake) begin
      note_tone_nxt  = hs_tone;
      // Invalid indices 21..29 play exactly like an explicit rest.
      note_swara_nxt = hs_tone ? note.note_idx : IDX_SILENT;
    end

    swara_idx_nxt = IDX_SILENT;
    tone_en_nxt   = 1'b0;
    case (next_state)
      S_PLAY: begin
        swara_idx_nxt = note_swara_nxt;
        tone_en_nxt   = note_tone_nxt;
      end
`ifdef SWARA_GAP_EN
      S_GAP: begin
        // The index is held through the gap so the generator only sees its enable drop.
        swara_idx_nxt = note_swara;
      end
`endif
      default: begin
      end
    endcase

    note_strobe_nxt = handshake && !hs_end;
    busy_nxt        = (next_state != S_IDLE);
    song_done_nxt   = (next_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      swara_idx   <= IDX_SILENT;
      tone_en     <= 1'b0;
      note_strobe <= 1'b0;
      busy        <= 1'b0;
      song_done   <= 1'b0;
      note_swara  <= IDX_SILENT;
      note_tone   <= 1'b0;
    end else begin
      swara_idx   <= swara_idx_nxt;
      tone_en     <= tone_en_nxt;
      note_strobe <= note_strobe_nxt;
      busy        <= busy_nxt;
      song_done   <= song_done_nxt;
      note_swara  <= stop ? IDX_SILENT : note_swara_nxt;
      note_tone   <= stop ? 1'b0 : note_tone_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat timing
  // ---------------------------------------------------------------------------
  // The tick counter runs 0..TICKS_PER_BEAT-1 within each beat while the beat counter counts down
  // from note_len; a tick wrap with the beat counter at zero is the end of the note. Both are held
  // at zero outside PLAY so an aborted note leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      beat_cnt <= '0;
    end else if (handshake) begin
      tick_cnt <= '0;
      beat_cnt <= note.note_len;
    end else if (state == S_PLAY && !stop) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        if (beat_cnt != 3'd0) beat_cnt <= beat_cnt - 3'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end else begin
      tick_cnt <= '0;
      beat_cnt <= '0;
    end
  end

endmodule
